// File: rtl/pc_stack_unit.sv
// Program-counter unit: selects the next fetch address (INC/JUMP/BRANCH/CALL/RET)
// and keeps return addresses in a circular LIFO with sticky overflow/underflow.
module pc_stack_unit #(
    parameter int unsigned            ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = '0,
    parameter int unsigned            STACK_DEPTH = 4,
    parameter int unsigned            CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [2:0]            op,
    input  logic                  cond,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic [ADDR_WIDTH-1:0] current_address,
    output logic [CNT_WIDTH-1:0]  stack_count,
    output logic                  overflow,
    output logic                  underflow
);

    typedef enum logic [2:0] {
        OP_INC    = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100
    } op_e;

    localparam int unsigned           PTR_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0]  LAST_PTR  = PTR_WIDTH'(STACK_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr_inc;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  push;
    logic                  pop;
    logic                  ret_empty;
    logic                  stack_full;
    logic                  stack_empty;

    // wr_ptr names the slot the next CALL writes; the top entry sits just below it.
    assign rd_ptr      = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PTR_WIDTH'(1);
    assign wr_ptr_inc  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
    assign seq_addr    = current_address + ADDR_WIDTH'(1);
    assign stack_full  = (stack_count == FULL_CNT);
    assign stack_empty = (stack_count == '0);

    always_comb begin
        next_addr = current_address;
        push      = 1'b0;
        pop       = 1'b0;
        ret_empty = 1'b0;
        if (enable) begin
            next_addr = seq_addr;
            case (op_e'(op))
                OP_JUMP:   next_addr = target;
                OP_BRANCH: if (cond) next_addr = current_address + offset;
                OP_CALL: begin
                    next_addr = target;
                    push      = 1'b1;
                end
                OP_RET: begin
                    if (stack_empty) begin
                        ret_empty = 1'b1;
                    end else begin
                        next_addr = stack_mem[rd_ptr];
                        pop       = 1'b1;
                    end
                end
                default: next_addr = seq_addr;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            current_address <= RESET_ADDR;
            stack_count     <= '0;
            wr_ptr          <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            current_address <= next_addr;
            if (push) begin
                // A full stack keeps its count; the write simply replaces the oldest slot.
                wr_ptr <= wr_ptr_inc;
                if (stack_full) overflow <= 1'b1;
                else            stack_count <= stack_count + CNT_WIDTH'(1);
            end else if (pop) begin
                wr_ptr      <= rd_ptr;
                stack_count <= stack_count - CNT_WIDTH'(1);
            end
            if (ret_empty) underflow <= 1'b1;
        end
    end

    // Stack contents need no reset; validity is tracked by stack_count alone.
    always_ff @(posedge clock) begin
        if (push) stack_mem[wr_ptr] <= seq_addr;
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed plan steps followed by random ops,
// all checked against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int unsigned   AW = 8;
    localparam int unsigned   D  = 4;
    localparam int unsigned   CW = $clog2(D + 1);
    localparam logic [AW-1:0] RA = 8'h10;

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable  = 1'b0;
    logic [2:0]    op      = '0;
    logic          cond    = 1'b0;
    logic [AW-1:0] target  = '0;
    logic [AW-1:0] offset  = '0;
    logic [AW-1:0] current_address;
    logic [CW-1:0] stack_count;
    logic          overflow;
    logic          underflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_stack [$];
    logic          m_ovf;
    logic          m_unf;

    pc_stack_unit #(
        .ADDR_WIDTH (AW),
        .RESET_ADDR (RA),
        .STACK_DEPTH(D)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .op             (op),
        .cond           (cond),
        .target         (target),
        .offset         (offset),
        .current_address(current_address),
        .stack_count    (stack_count),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = RA;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".addr"}, 32'(current_address), 32'(m_addr));
        chk({tag, ".count"}, 32'(stack_count), 32'(m_stack.size()));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // Drive one op, let one edge pass, advance the model, check just after the edge.
    task automatic do_op(input string tag, input logic en, input logic [2:0] o,
                         input logic c, input logic [AW-1:0] t, input logic [AW-1:0] off);
        enable = en;
        op     = o;
        cond   = c;
        target = t;
        offset = off;
        @(posedge clock);
        if (en) begin
            case (o)
                JMP: m_addr = t;
                BR:  m_addr = c ? m_addr + off : m_addr + 8'd1;
                CALL: begin
                    if (m_stack.size() == D) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_stack.push_back(m_addr + 8'd1);
                    m_addr = t;
                end
                RET: begin
                    if (m_stack.size() > 0) m_addr = m_stack.pop_back();
                    else begin
                        m_addr = m_addr + 8'd1;
                        m_unf  = 1'b1;
                    end
                end
                default: m_addr = m_addr + 8'd1;
            endcase
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_model("reset");
        chk("reset_addr", 32'(current_address), 32'h10);

        @(negedge clock);
        reset_n = 1'b1;
        do_op("inc1", 1, INC, 0, 0, 0);
        chk("inc1_val", 32'(current_address), 32'h11);
        do_op("inc2", 1, INC, 0, 0, 0);
        do_op("inc3", 1, INC, 0, 0, 0);
        chk("inc3_val", 32'(current_address), 32'h13);

        do_op("jff", 1, JMP, 0, 8'hFF, 0);
        do_op("wrap", 1, INC, 0, 0, 0);
        chk("wrap_val", 32'(current_address), 32'h00);
        do_op("j05a", 1, JMP, 0, 8'h05, 0);
        do_op("br_back", 1, BR, 1, 0, 8'hFE);
        chk("br_back_val", 32'(current_address), 32'h03);
        do_op("j05b", 1, JMP, 0, 8'h05, 0);
        do_op("br_nt", 1, BR, 0, 0, 8'hFE);
        chk("br_nt_val", 32'(current_address), 32'h06);

        do_op("j20", 1, JMP, 0, 8'h20, 0);
        do_op("call80", 1, CALL, 0, 8'h80, 0);
        chk("call80_cnt", 32'(stack_count), 32'd1);
        do_op("inc81", 1, INC, 0, 0, 0);
        do_op("ret21", 1, RET, 0, 0, 0);
        chk("ret21_val", 32'(current_address), 32'h21);
        do_op("j30", 1, JMP, 0, 8'h30, 0);
        do_op("call40", 1, CALL, 0, 8'h40, 0);
        do_op("ret31", 1, RET, 0, 0, 0);
        chk("ret31_val", 32'(current_address), 32'h31);

        do_op("j00", 1, JMP, 0, 8'h00, 0);
        for (int i = 1; i <= 5; i++)
            do_op("ovf_call", 1, CALL, 0, 8'(i * 16), 0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(stack_count), 32'd4);
        do_op("ovf_ret1", 1, RET, 0, 0, 0);
        chk("ovf_ret1_val", 32'(current_address), 32'h41);
        do_op("ovf_ret2", 1, RET, 0, 0, 0);
        do_op("ovf_ret3", 1, RET, 0, 0, 0);
        do_op("ovf_ret4", 1, RET, 0, 0, 0);
        chk("ovf_ret4_val", 32'(current_address), 32'h11);
        do_op("unf_ret", 1, RET, 0, 0, 0);
        chk("unf_val", 32'(current_address), 32'h12);
        chk("unf_flag", 32'(underflow), 32'd1);

        for (int i = 0; i < 3; i++)
            do_op("stall", 0, CALL, 0, 8'h99, 0);
        chk("stall_val", 32'(current_address), 32'h12);

        reset_n = 1'b0;
        #2;
        model_reset();
        check_model("rst2");
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++)
            do_op("pre_call", 1, CALL, 0, 8'(i), 0);
        do_op("j55", 1, JMP, 0, 8'h55, 0);
        chk("pre_rst_cnt", 32'(stack_count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        do_op("post_rst_ret", 1, RET, 0, 0, 0);
        chk("post_rst_val", 32'(current_address), 32'h11);
        chk("post_rst_unf", 32'(underflow), 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] ro;
            ro = (i % 3 == 0) ? 3'($urandom_range(3, 4)) : 3'($urandom_range(0, 7));
            do_op("rand", 1'($urandom_range(0, 3) != 0), ro, 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom));
            if (i == 200) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                check_model("rand_rst");
                @(negedge clock);
                reset_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the processor's control path. It holds the fetch address presented to the unified memory. Each enabled clock it selects the next address: sequential increment, absolute jump, conditional PC-relative branch, subroutine call, or return. Calls and returns use an internal return-address stack of configurable depth, with sticky overflow/underflow status.

## Interface
- ADDR_WIDTH, 8, width of all addresses; arithmetic is modulo 2^ADDR_WIDTH
- RESET_ADDR, 0, value loaded into current_address on reset
- STACK_DEPTH, 4, number of return-address entries (≥1)
- CNT_WIDTH, $clog2(STACK_DEPTH+1), width of stack_count
- clock  input  1  rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- enable  input  1  1 = perform op this edge; 0 = hold everything (stall)
- op  input  3  000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101–111 reserved (behave as INC)
- cond  input  1  branch condition, used only by BRANCH
- target  input  ADDR_WIDTH  absolute destination for JUMP and CALL
- offset  input  ADDR_WIDTH  two's-complement displacement for BRANCH, relative to current_address
- current_address  output  ADDR_WIDTH  registered fetch address
- stack_count  output  CNT_WIDTH  valid stack entries, 0..STACK_DEPTH
- overflow  output  1  sticky; set by CALL when the stack is full
- underflow  output  1  sticky; set by RET when the stack is empty

## Operation
- Reset (reset_n=0) forces current_address=RESET_ADDR, stack_count=0, overflow=0, underflow=0. Stack RAM contents are don't-care.
- With enable=1, on a rising edge, where A = current_address:
  - INC: A+1.
  - JUMP: target.
  - BRANCH: A+offset if cond=1, else A+1.
  - CALL: push A+1, then A = target.
  - RET with stack_count>0: pop the top entry into A.
  - RET with stack_count=0: A+1, stack unchanged, underflow set.
- Stack is a circular LIFO with a top pointer modulo STACK_DEPTH.
- CALL with stack_count=STACK_DEPTH overwrites the oldest entry. stack_count stays at STACK_DEPTH and overflow is set. The jump still occurs.
- After overflow, RETs return the STACK_DEPTH most recent return addresses in LIFO order. The next RET underflows.
- All additions wrap modulo 2^ADDR_WIDTH, with no carry or status. Offset is sign-extended to ADDR_WIDTH, which is a no-op at equal width.
- overflow and underflow clear only on reset.
- enable=0 ignores op entirely: no address change, no push/pop, no flag change.

## Timing
- Fully synchronous update on the rising edge of clock. current_address reflects the op sampled at edge N immediately after edge N, so there is one cycle of latency from op to address.
- stack_count, overflow and underflow update on the same edge as the address they accompany.
- Inputs op, cond, target and offset must be stable around the edge. They are combinationally consumed and not registered.
- Reset is asserted asynchronously: outputs go to reset values without waiting for a clock edge. Deassertion is synchronised externally.
- Reset mid-sequence (stack non-empty) discards all stack state. The first RET after reset underflows.
- No handshake: the block accepts one op per enabled cycle, back-to-back, including CALL immediately followed by RET.

## Test plan
- Reset/INC: RESET_ADDR=0x10, hold reset_n=0 → current_address=0x10, stack_count=0, flags 0. Release, then 3×INC → 0x11, 0x12, 0x13.
- Wrap/branch: at 0xFF, INC → 0x00. At 0x05, BRANCH offset=0xFE cond=1 → 0x03. At 0x05, cond=0 → 0x06.
- Call/return: at 0x20, CALL target=0x80 → 0x80, count 1. INC → 0x81. RET → 0x21, count 0. Back-to-back CALL 0x40 then RET from 0x30 → 0x40 then 0x31.
- Overflow/underflow (STACK_DEPTH=4): CALLs from 0x00, 0x10, 0x20, 0x30, 0x40 → overflow=1, count 4.
  - RETs return 0x41, 0x31, 0x21, 0x11.
  - A 5th RET at 0x11 → 0x12, underflow=1, count 0.
- Stall: enable=0 with op=CALL target=0x99 for 3 cycles → address, count and flags unchanged.
- Async reset mid-stack: count=3, address 0x55. Drive reset_n low between edges → current_address=RESET_ADDR, count 0 before the next edge. After release, RET → RESET_ADDR+1, underflow=1.
